// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - sliding-window pixel address generator, column-major within each window
// Optional macro WINDOW_BORDER_CLAMP_EN clamps out-of-frame coordinates to the nearest edge pixel.
module window_addr_gen #(
    parameter int ADDR_W = 17,
    parameter int ROW_W  = 11,
    parameter int COL_W  = 11,
    parameter int WIN    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  rowMax,
    input  logic [COL_W-1:0]  colMax,
    input  logic [1:0]        stride,
    input  logic              addrReady,
    output logic [ADDR_W-1:0] address,
    output logic              addrStrobe,
    output logic              addrInBounds,
    output logic              colUpdate,
    output logic              winValid,
    output logic [ROW_W-1:0]  winRow,
    output logic [COL_W-1:0]  winCol,
    output logic              rowStart,
    output logic              busy,
    output logic              done
);
    localparam int H  = (WIN - 1) / 2;
    localparam int PW = $clog2(WIN);
    localparam int MW = ROW_W + COL_W + 1;
    localparam logic [PW-1:0] LAST_POS = PW'(WIN - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FILL  = 4'b0010,
        SLIDE = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t           state, state_nxt;
    logic [ROW_W-1:0] rows_q, rows_nxt;
    logic [COL_W-1:0] cols_q, cols_nxt;
    logic [1:0]       step_q, step_nxt;
    logic [ROW_W-1:0] win_row_q, win_row_nxt;
    logic [COL_W-1:0] win_col_q, win_col_nxt;
    logic [PW-1:0]    row_pos_q, row_pos_nxt;
    logic [PW-1:0]    col_pos_q, col_pos_nxt;
    logic [PW-1:0]    slide_pos;
    logic [ROW_W:0]   row_step_sum;
    logic [COL_W:0]   col_step_sum;
    logic             accept;

    assign accept = addrStrobe & addrReady;

    // A slide window only re-emits the N newest columns; col_pos is the column index inside the window.
    always_comb begin
        slide_pos = (int'(step_q) >= WIN) ? '0 : PW'(WIN - int'(step_q));
    end

    always_comb begin
        state_nxt    = state;
        rows_nxt     = rows_q;
        cols_nxt     = cols_q;
        step_nxt     = step_q;
        win_row_nxt  = win_row_q;
        win_col_nxt  = win_col_q;
        row_pos_nxt  = row_pos_q;
        col_pos_nxt  = col_pos_q;
        row_step_sum = {1'b0, win_row_q} + (ROW_W+1)'(step_q);
        col_step_sum = {1'b0, win_col_q} + (COL_W+1)'(step_q);
        unique case (state)
            IDLE: begin
                if (start) begin
                    rows_nxt    = rowMax;
                    cols_nxt    = colMax;
                    step_nxt    = (stride == 2'd0) ? 2'd1 : stride;
                    win_row_nxt = '0;
                    win_col_nxt = '0;
                    row_pos_nxt = '0;
                    col_pos_nxt = '0;
                    state_nxt   = (rowMax == '0 || colMax == '0) ? DONE : FILL;
                end
            end
            FILL, SLIDE: begin
                if (accept) begin
                    if (row_pos_q != LAST_POS) begin
                        row_pos_nxt = row_pos_q + 1'b1;
                    end else if (col_pos_q != LAST_POS) begin
                        row_pos_nxt = '0;
                        col_pos_nxt = col_pos_q + 1'b1;
                    end else begin
                        row_pos_nxt = '0;
                        if (col_step_sum >= {1'b0, cols_q}) begin
                            win_col_nxt = '0;
                            col_pos_nxt = '0;
                            if (row_step_sum >= {1'b0, rows_q}) begin
                                state_nxt   = DONE;
                                win_row_nxt = '0;
                            end else begin
                                state_nxt   = FILL;
                                win_row_nxt = row_step_sum[ROW_W-1:0];
                            end
                        end else begin
                            state_nxt   = SLIDE;
                            win_col_nxt = col_step_sum[COL_W-1:0];
                            col_pos_nxt = slide_pos;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                win_row_nxt = '0;
                win_col_nxt = '0;
                row_pos_nxt = '0;
                col_pos_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are derived from the next-cycle counters so every port comes straight from a flop.
    logic                emit_nxt;
    logic signed [ROW_W:0] r;
    logic signed [COL_W:0] c;
    logic                inb_nxt;
    logic [ROW_W-1:0]    r_sel;
    logic [COL_W-1:0]    c_sel;
    logic [MW-1:0]       addr_full;
    logic [ADDR_W-1:0]   address_nxt;
    logic                col_update_nxt;
    logic                win_valid_nxt;

    always_comb begin
        emit_nxt = (state_nxt == FILL) || (state_nxt == SLIDE);
        r = $signed({1'b0, win_row_nxt}) + $signed({{(ROW_W+1-PW){1'b0}}, row_pos_nxt})
            - $signed((ROW_W+1)'(H));
        c = $signed({1'b0, win_col_nxt}) + $signed({{(COL_W+1-PW){1'b0}}, col_pos_nxt})
            - $signed((COL_W+1)'(H));
        inb_nxt = emit_nxt && !r[ROW_W] && (r < $signed({1'b0, rows_nxt}))
                  && !c[COL_W] && (c < $signed({1'b0, cols_nxt}));
`ifdef WINDOW_BORDER_CLAMP_EN
        if (r[ROW_W]) begin
            r_sel = '0;
        end else if (r >= $signed({1'b0, rows_nxt})) begin
            r_sel = rows_nxt - 1'b1;
        end else begin
            r_sel = r[ROW_W-1:0];
        end
        if (c[COL_W]) begin
            c_sel = '0;
        end else if (c >= $signed({1'b0, cols_nxt})) begin
            c_sel = cols_nxt - 1'b1;
        end else begin
            c_sel = c[COL_W-1:0];
        end
        addr_full   = MW'(r_sel) * MW'(cols_nxt) + MW'(c_sel);
        address_nxt = emit_nxt ? ADDR_W'(addr_full) : '0;
`else
        r_sel       = r[ROW_W-1:0];
        c_sel       = c[COL_W-1:0];
        addr_full   = MW'(r_sel) * MW'(cols_nxt) + MW'(c_sel);
        address_nxt = inb_nxt ? ADDR_W'(addr_full) : '0;
`endif
        col_update_nxt = emit_nxt && (row_pos_nxt == LAST_POS);
        win_valid_nxt  = col_update_nxt && (col_pos_nxt == LAST_POS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            step_q       <= 2'd1;
            win_row_q    <= '0;
            win_col_q    <= '0;
            row_pos_q    <= '0;
            col_pos_q    <= '0;
            address      <= '0;
            addrStrobe   <= 1'b0;
            addrInBounds <= 1'b0;
            colUpdate    <= 1'b0;
            winValid     <= 1'b0;
            winRow       <= '0;
            winCol       <= '0;
            rowStart     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            rows_q       <= rows_nxt;
            cols_q       <= cols_nxt;
            step_q       <= step_nxt;
            win_row_q    <= win_row_nxt;
            win_col_q    <= win_col_nxt;
            row_pos_q    <= row_pos_nxt;
            col_pos_q    <= col_pos_nxt;
            address      <= address_nxt;
            addrStrobe   <= emit_nxt;
            addrInBounds <= inb_nxt;
            colUpdate    <= col_update_nxt;
            winValid     <= win_valid_nxt;
            winRow       <= win_row_nxt;
            winCol       <= win_col_nxt;
            rowStart     <= (state_nxt == FILL);
            busy         <= emit_nxt;
            done         <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_window_addr_gen.sv
// tb/tb_window_addr_gen.sv - self-checking bench for window_addr_gen (WIN=3)
module tb_window_addr_gen;
    localparam int ADDR_W = 17;
    localparam int ROW_W  = 11;
    localparam int COL_W  = 11;
    localparam int WIN    = 3;
    localparam int H      = (WIN - 1) / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ROW_W-1:0]  rowMax;
    logic [COL_W-1:0]  colMax;
    logic [1:0]        stride;
    logic              addrReady;
    logic [ADDR_W-1:0] address;
    logic              addrStrobe;
    logic              addrInBounds;
    logic              colUpdate;
    logic              winValid;
    logic [ROW_W-1:0]  winRow;
    logic [COL_W-1:0]  winCol;
    logic              rowStart;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    window_addr_gen #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W), .WIN(WIN)) dut (
        .clk(clk), .rst(rst), .start(start), .rowMax(rowMax), .colMax(colMax),
        .stride(stride), .addrReady(addrReady), .address(address), .addrStrobe(addrStrobe),
        .addrInBounds(addrInBounds), .colUpdate(colUpdate), .winValid(winValid),
        .winRow(winRow), .winCol(winCol), .rowStart(rowStart), .busy(busy), .done(done)
    );

    typedef struct {
        int r;
        int c;
        int wr;
        int wc;
        bit cu;
        bit wv;
        bit rs;
    } exp_t;

    exp_t              q[$];
    logic [ADDR_W-1:0] cap_addr[$];
    logic              cap_inb[$];

    // Reference: enumerate windows row by row, emitting every coordinate a window needs.
    task automatic build_model(input int rows, input int cols, input int strd);
        int s;
        int n;
        int c0;
        exp_t e;
        s = (strd == 0) ? 1 : strd;
        n = (s < WIN) ? s : WIN;
        q.delete();
        for (int wr = 0; wr < rows; wr += s) begin
            for (int wc = 0; wc < cols; wc += s) begin
                c0 = (wc == 0) ? wc - H : wc + H - n + 1;
                for (int cc = c0; cc <= wc + H; cc++) begin
                    for (int rr = wr - H; rr <= wr + H; rr++) begin
                        e.r  = rr;
                        e.c  = cc;
                        e.wr = wr;
                        e.wc = wc;
                        e.cu = (rr == wr + H);
                        e.wv = (rr == wr + H) && (cc == wc + H);
                        e.rs = (wc == 0);
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    function automatic bit exp_inb(int r, int c, int rows, int cols);
        return (r >= 0) && (r < rows) && (c >= 0) && (c < cols);
    endfunction

    function automatic int exp_addr(int r, int c, int rows, int cols);
        int rr;
        int cc;
        rr = r;
        cc = c;
`ifdef WINDOW_BORDER_CLAMP_EN
        if (rr < 0) rr = 0;
        if (rr > rows - 1) rr = rows - 1;
        if (cc < 0) cc = 0;
        if (cc > cols - 1) cc = cols - 1;
        return (rr * cols + cc) % (1 << ADDR_W);
`else
        if (!exp_inb(rr, cc, rows, cols)) return 0;
        return (rr * cols + cc) % (1 << ADDR_W);
`endif
    endfunction

    task automatic run_frame(input int rows, input int cols, input int strd, input int stall_pct,
                             input int stall_at, input bit disturb,
                             output int n_acc, output int n_win, output int done_cyc);
        exp_t              e;
        int                cyc;
        int                stall_left;
        bit                stalled_once;
        bit                rdy;
        bit                ei;
        int                ea;
        int                idx;
        logic [ADDR_W-1:0] held;
        build_model(rows, cols, strd);
        cap_addr.delete();
        cap_inb.delete();
        n_acc = 0; n_win = 0; done_cyc = -1; stall_left = 0; stalled_once = 0; held = '0; idx = 0;
        start = 1'b1; rowMax = ROW_W'(rows); colMax = COL_W'(cols); stride = 2'(strd);
        addrReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 4000) begin
            if (addrStrobe) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_strobe cycle=%0d addr=%0d required no strobe", cyc, address);
                end else begin
                    e  = q[0];
                    ea = exp_addr(e.r, e.c, rows, cols);
                    ei = exp_inb(e.r, e.c, rows, cols);
                    if ({address, addrInBounds, colUpdate, winValid, winRow, winCol, rowStart, busy} !==
                        {ADDR_W'(ea), ei, e.cu, e.wv, ROW_W'(e.wr), COL_W'(e.wc), e.rs, 1'b1}) begin
                        failures++;
                        $display("FAIL strobe%0d got addr=%0d inb=%b cu=%b wv=%b win=(%0d,%0d) rs=%b busy=%b want addr=%0d inb=%b cu=%b wv=%b win=(%0d,%0d) rs=%b busy=1",
                                 idx + 1, address, addrInBounds, colUpdate, winValid, winRow, winCol,
                                 rowStart, busy, ea, ei, e.cu, e.wv, e.wr, e.wc, e.rs);
                    end
                end
            end else if (done) begin
                done_cyc = cyc;
            end else begin
                checks++;
                failures++;
                $display("FAIL strobe_gap cycle=%0d addrStrobe=0 done=0 required one of them", cyc);
            end
            if (stall_at > 0 && !stalled_once && addrStrobe && n_acc == stall_at - 1) begin
                stall_left   = 3;
                stalled_once = 1;
                held         = address;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                checks++;
                if (address !== held) begin
                    failures++;
                    $display("FAIL stall_hold got addr=%0d required %0d", address, held);
                end
                stall_left--;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            addrReady = rdy;
            if (addrStrobe && rdy) begin
                n_acc++;
                idx++;
                if (winValid) n_win++;
                cap_addr.push_back(address);
                cap_inb.push_back(addrInBounds);
                if (q.size() > 0) void'(q.pop_front());
            end
            if (disturb && done_cyc < 0) begin
                start  = 1'($urandom_range(1));
                rowMax = ROW_W'($urandom);
                colMax = COL_W'($urandom);
                stride = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        addrReady = 1'b1;
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL frame_timeout got no done within %0d cycles required done", cyc);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes got %0d unissued required 0", q.size());
        end
        checks++;
        if ({busy, done, addrStrobe, winRow, winCol} !== '0) begin
            failures++;
            $display("FAIL post_done busy=%b done=%b strobe=%b win=(%0d,%0d) required all 0",
                     busy, done, addrStrobe, winRow, winCol);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; addrReady = 1'b1; rowMax = 11'd4; colMax = 11'd4; stride = 2'd1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({address, addrStrobe, addrInBounds, colUpdate, winValid, rowStart, winRow, winCol, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_state addr=%0d strobe=%b inb=%b cu=%b wv=%b rs=%b win=(%0d,%0d) busy=%b done=%b required all 0",
                     address, addrStrobe, addrInBounds, colUpdate, winValid, rowStart, winRow, winCol, busy, done);
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_basic();
        int n_acc, n_win, done_cyc;
        int last_exp;
`ifdef WINDOW_BORDER_CLAMP_EN
        last_exp = 15;
`else
        last_exp = 0;
`endif
        run_frame(4, 4, 1, 0, 0, 0, n_acc, n_win, done_cyc);
        checks++;
        if (n_acc != 72) begin failures++; $display("FAIL basic_strobes got %0d required 72", n_acc); end
        checks++;
        if (n_win != 16) begin failures++; $display("FAIL basic_windows got %0d required 16", n_win); end
        checks++;
        if (done_cyc != 73) begin failures++; $display("FAIL basic_done_cycle got %0d required 73", done_cyc); end
        checks++;
        if (cap_addr.size() < 72) begin
            failures++;
            $display("FAIL basic_captured got %0d required 72", cap_addr.size());
        end else begin
            if ({cap_addr[0], cap_inb[0]} !== {17'd0, 1'b0}) begin
                failures++;
                $display("FAIL strobe1_corner got addr=%0d inb=%b required 0/0", cap_addr[0], cap_inb[0]);
            end
            checks++;
            if ({cap_addr[4], cap_inb[4]} !== {17'd0, 1'b1}) begin
                failures++;
                $display("FAIL strobe5_origin got addr=%0d inb=%b required 0/1", cap_addr[4], cap_inb[4]);
            end
            checks++;
            if ({cap_addr[5], cap_inb[5]} !== {17'd4, 1'b1}) begin
                failures++;
                $display("FAIL strobe6_row1 got addr=%0d inb=%b required 4/1", cap_addr[5], cap_inb[5]);
            end
            checks++;
            if (cap_addr[71] !== ADDR_W'(last_exp)) begin
                failures++;
                $display("FAIL last_strobe_addr got %0d required %0d", cap_addr[71], last_exp);
            end
        end
    endtask

    task automatic test_stall();
        int n_acc, n_win, done_cyc;
        run_frame(4, 4, 1, 0, 10, 0, n_acc, n_win, done_cyc);
        checks++;
        if (n_acc != 72) begin failures++; $display("FAIL stall_strobes got %0d required 72", n_acc); end
        checks++;
        if (done_cyc != 76) begin failures++; $display("FAIL stall_done_cycle got %0d required 76", done_cyc); end
    endtask

    task automatic test_stride2();
        int n_acc, n_win, done_cyc;
        run_frame(6, 6, 2, 0, 0, 0, n_acc, n_win, done_cyc);
        checks++;
        if (n_acc != 63) begin failures++; $display("FAIL stride2_strobes got %0d required 63", n_acc); end
        checks++;
        if (n_win != 9) begin failures++; $display("FAIL stride2_windows got %0d required 9", n_win); end
        checks++;
        if (done_cyc != 64) begin failures++; $display("FAIL stride2_done_cycle got %0d required 64", done_cyc); end
    endtask

    task automatic test_zero_dims();
        int n_acc, n_win, done_cyc;
        run_frame(0, 5, 1, 0, 0, 0, n_acc, n_win, done_cyc);
        checks++;
        if (n_acc != 0 || done_cyc != 1) begin
            failures++;
            $display("FAIL zero_rows got strobes=%0d done_cycle=%0d required 0/1", n_acc, done_cyc);
        end
        run_frame(3, 0, 2, 0, 0, 0, n_acc, n_win, done_cyc);
        checks++;
        if (n_acc != 0 || done_cyc != 1) begin
            failures++;
            $display("FAIL zero_cols got strobes=%0d done_cycle=%0d required 0/1", n_acc, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int cyc;
        acc = 0; cyc = 0;
        start = 1'b1; rowMax = 11'd4; colMax = 11'd4; stride = 2'd1; addrReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (acc < 19 && cyc < 200) begin
            if (addrStrobe) acc++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (addrStrobe !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre got strobe=%b required 1", addrStrobe);
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        checks++;
        if ({address, addrStrobe, addrInBounds, colUpdate, winValid, rowStart, winRow, winCol, busy, done} !== '0) begin
            failures++;
            $display("FAIL midreset_zero addr=%0d strobe=%b busy=%b win=(%0d,%0d) required all 0",
                     address, addrStrobe, busy, winRow, winCol);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({addrStrobe, address, addrInBounds, winRow, winCol, rowStart} !== {1'b1, 17'd0, 1'b0, 11'd0, 11'd0, 1'b1}) begin
            failures++;
            $display("FAIL restart_first got strobe=%b addr=%0d inb=%b win=(%0d,%0d) rs=%b required 1/0/0/(0,0)/1",
                     addrStrobe, address, addrInBounds, winRow, winCol, rowStart);
        end
        acc = 0; cyc = 0;
        while (!done && cyc < 300) begin
            if (addrStrobe) acc++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (acc != 72 || !done) begin
            failures++;
            $display("FAIL restart_frame got strobes=%0d done=%b required 72/1", acc, done);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n_acc, n_win, done_cyc;
        int rows, cols, strd, s, exp_win;
        for (int i = 0; i < 8; i++) begin
            rows = $urandom_range(9, 1);
            cols = $urandom_range(9, 1);
            strd = $urandom_range(3, 0);
            s = (strd == 0) ? 1 : strd;
            exp_win = ((rows + s - 1) / s) * ((cols + s - 1) / s);
            run_frame(rows, cols, strd, 30, 0, 1, n_acc, n_win, done_cyc);
            checks++;
            if (n_win != exp_win) begin
                failures++;
                $display("FAIL random_windows frame=%0d %0dx%0d s=%0d got %0d required %0d",
                         i, rows, cols, strd, n_win, exp_win);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rowMax = '0; colMax = '0; stride = '0; addrReady = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_stride2();
        test_zero_dims();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
